// File: rtl/qconv_ctrl_pkg.sv
// Shared definitions for the qconv loop sequencer: engine bit positions,
// the per-level state encoding and the trip-count clamp.
package qconv_ctrl_pkg;

    localparam int NUM_ENG         = 6;
    localparam int ENG_READ_INDATA = 0;
    localparam int ENG_INIT_OUTBUF = 1;
    localparam int ENG_READ_KERNEL = 2;
    localparam int ENG_IC          = 3;
    localparam int ENG_THRESHOLDS  = 4;
    localparam int ENG_OUTPUT      = 5;

    // Widest trip count the clamp helper handles; callers cast to their width.
    localparam int CNT_MAX_W = 16;

    // Single-phase levels (ihw_low) use TRIG_A/WAIT_A as their TRIG/WAIT.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG_A,
        ST_WAIT_A,
        ST_TRIG_B,
        ST_WAIT_B,
        ST_NEXT
    } level_state_e;

    // A programmed count of zero runs the loop once.
    function automatic logic [CNT_MAX_W-1:0] clamp_count(input logic [CNT_MAX_W-1:0] n);
        return (n == '0) ? CNT_MAX_W'(1) : n;
    endfunction

endpackage

// File: rtl/qconv_loop_idx2d.sv
// Two-dimensional h/w loop index: w runs fastest, h steps when w wraps.
// is_last flags the final (num_h-1, num_w-1) iteration.
module qconv_loop_idx2d #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         advance,
    input  logic [W-1:0] num_h,
    input  logic [W-1:0] num_w,
    output logic [W-1:0] h,
    output logic [W-1:0] w,
    output logic         is_last
);

    logic w_wrap;

    assign w_wrap  = (w == num_w - W'(1));
    assign is_last = w_wrap && (h == num_h - W'(1));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in the design samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            h <= '0;
            w <= '0;
        end else if (advance) begin
            if (w_wrap) begin
                w <= '0;
                h <= h + W'(1);
            end else begin
                w <= w + W'(1);
            end
        end
    end

endmodule

// File: rtl/qconv_loop_ctrl.sv
// Runtime-configurable four-level loop sequencer for the qconv datapath.
// Each level is a small FSM that triggers engines/children and waits for their finish.
module qconv_loop_ctrl
    import qconv_ctrl_pkg::*;
#(
    parameter int OC_W = 8,
    parameter int HW_W = 8,
    parameter int K_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [OC_W-1:0]    cfg_oc_num,
    input  logic [HW_W-1:0]    cfg_ihh_num,
    input  logic [HW_W-1:0]    cfg_iwh_num,
    input  logic [K_W-1:0]     cfg_kh_num,
    input  logic [K_W-1:0]     cfg_kw_num,
    input  logic [HW_W-1:0]    cfg_ihl_num,
    input  logic [HW_W-1:0]    cfg_iwl_num,
    input  logic               cfg_thr_en,
    output logic [NUM_ENG-1:0] eng_start,
    input  logic [NUM_ENG-1:0] eng_done,
    output logic               busy,
    output logic               done,
    output logic [OC_W-1:0]    oc_high,
    output logic [HW_W-1:0]    ih_high,
    output logic [HW_W-1:0]    iw_high,
    output logic [K_W-1:0]     kh,
    output logic [K_W-1:0]     kw,
    output logic [HW_W-1:0]    ih_low,
    output logic [HW_W-1:0]    iw_low
);

    level_state_e oc_st, hh_st, kk_st, ll_st;

    logic               kill;
    logic               accept;
    logic [OC_W-1:0]    oc_num_q;
    logic [OC_W-1:0]    oc_idx;
    logic [HW_W-1:0]    ihh_num_q, iwh_num_q, ihl_num_q, iwl_num_q;
    logic [K_W-1:0]     kh_num_q, kw_num_q;
    logic               thr_en_q;

    logic [NUM_ENG-1:0] eng_start_w;
    logic [NUM_ENG-1:0] eng_pend;
    logic [NUM_ENG-1:0] eng_flag;
    logic [NUM_ENG-1:0] eng_ok;
    logic               thr_ok;

    logic hh_go, kk_go, ll_go;
    logic hh_fin, kk_fin, ll_fin;
    logic hh_fin_flag, kk_fin_flag, ll_fin_flag;
    logic oc_last, hh_last, kk_last, ll_last;
    logic hh_clr, kk_clr, ll_clr;
    logic hh_adv, kk_adv, ll_adv;

    assign kill   = rst || abort;
    assign accept = start && (oc_st == ST_IDLE) && !kill;

    // NOTE: the job configuration is deliberately left without reset; it is
    // rewritten on every accepted start and only consulted while busy.
    always_ff @(posedge clk) begin
        if (accept) begin
            oc_num_q  <= OC_W'(clamp_count(CNT_MAX_W'(cfg_oc_num)));
            ihh_num_q <= HW_W'(clamp_count(CNT_MAX_W'(cfg_ihh_num)));
            iwh_num_q <= HW_W'(clamp_count(CNT_MAX_W'(cfg_iwh_num)));
            kh_num_q  <= K_W'(clamp_count(CNT_MAX_W'(cfg_kh_num)));
            kw_num_q  <= K_W'(clamp_count(CNT_MAX_W'(cfg_kw_num)));
            ihl_num_q <= HW_W'(clamp_count(CNT_MAX_W'(cfg_ihl_num)));
            iwl_num_q <= HW_W'(clamp_count(CNT_MAX_W'(cfg_iwl_num)));
            thr_en_q  <= cfg_thr_en;
        end
    end

    // Start pulses are pure decodes of the level states, suppressed in an abort/reset cycle.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        eng_start_w = '0;
        eng_start_w[ENG_READ_INDATA] = (hh_st == ST_TRIG_A);
        eng_start_w[ENG_INIT_OUTBUF] = (hh_st == ST_TRIG_A);
        eng_start_w[ENG_READ_KERNEL] = (kk_st == ST_TRIG_A);
        eng_start_w[ENG_IC]          = (ll_st == ST_TRIG_A);
        eng_start_w[ENG_THRESHOLDS]  = (oc_st == ST_TRIG_A) && thr_en_q;
        eng_start_w[ENG_OUTPUT]      = (oc_st == ST_TRIG_B);
        if (kill) begin
            eng_start_w = '0;
        end
    end

    assign eng_start = eng_start_w;

    // A done pulse only counts while its engine has an outstanding start.
    always_ff @(posedge clk) begin
        if (kill) begin
            eng_pend <= '0;
            eng_flag <= '0;
        end else begin
            for (int i = 0; i < NUM_ENG; i++) begin
                if (eng_start_w[i]) begin
                    eng_pend[i] <= 1'b1;
                    eng_flag[i] <= 1'b0;
                end else if (eng_done[i] && eng_pend[i]) begin
                    eng_pend[i] <= 1'b0;
                    eng_flag[i] <= 1'b1;
                end
            end
        end
    end

    assign eng_ok = eng_flag | (eng_done & eng_pend);
    assign thr_ok = !thr_en_q || eng_ok[ENG_THRESHOLDS];

    assign hh_go  = (oc_st == ST_TRIG_A);
    assign kk_go  = (hh_st == ST_TRIG_B);
    assign ll_go  = (kk_st == ST_TRIG_B);
    assign hh_fin = (hh_st == ST_NEXT) && hh_last;
    assign kk_fin = (kk_st == ST_NEXT) && kk_last;
    assign ll_fin = (ll_st == ST_NEXT) && ll_last;

    always_ff @(posedge clk) begin
        if (kill) begin
            hh_fin_flag <= 1'b0;
            kk_fin_flag <= 1'b0;
            ll_fin_flag <= 1'b0;
        end else begin
            if (hh_go)       hh_fin_flag <= 1'b0;
            else if (hh_fin) hh_fin_flag <= 1'b1;
            if (kk_go)       kk_fin_flag <= 1'b0;
            else if (kk_fin) kk_fin_flag <= 1'b1;
            if (ll_go)       ll_fin_flag <= 1'b0;
            else if (ll_fin) ll_fin_flag <= 1'b1;
        end
    end

    assign oc_last = (oc_idx == oc_num_q - OC_W'(1));

    always_ff @(posedge clk) begin
        if (kill) begin
            oc_st  <= ST_IDLE;
            oc_idx <= '0;
        end else begin
            case (oc_st)
                ST_IDLE:   if (start) oc_st <= ST_TRIG_A;
                ST_TRIG_A: oc_st <= ST_WAIT_A;
                ST_WAIT_A: if (thr_ok && (hh_fin_flag || hh_fin)) oc_st <= ST_TRIG_B;
                ST_TRIG_B: oc_st <= ST_WAIT_B;
                ST_WAIT_B: if (eng_ok[ENG_OUTPUT]) oc_st <= ST_NEXT;
                ST_NEXT: begin
                    if (oc_last) begin
                        oc_st  <= ST_IDLE;
                        oc_idx <= '0;
                    end else begin
                        oc_st  <= ST_TRIG_A;
                        oc_idx <= oc_idx + OC_W'(1);
                    end
                end
                default:   oc_st <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            hh_st <= ST_IDLE;
        end else begin
            case (hh_st)
                ST_IDLE:   if (hh_go) hh_st <= ST_TRIG_A;
                ST_TRIG_A: hh_st <= ST_WAIT_A;
                ST_WAIT_A: if (eng_ok[ENG_READ_INDATA] && eng_ok[ENG_INIT_OUTBUF]) hh_st <= ST_TRIG_B;
                ST_TRIG_B: hh_st <= ST_WAIT_B;
                ST_WAIT_B: if (kk_fin_flag || kk_fin) hh_st <= ST_NEXT;
                ST_NEXT:   hh_st <= hh_last ? ST_IDLE : ST_TRIG_A;
                default:   hh_st <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            kk_st <= ST_IDLE;
        end else begin
            case (kk_st)
                ST_IDLE:   if (kk_go) kk_st <= ST_TRIG_A;
                ST_TRIG_A: kk_st <= ST_WAIT_A;
                ST_WAIT_A: if (eng_ok[ENG_READ_KERNEL]) kk_st <= ST_TRIG_B;
                ST_TRIG_B: kk_st <= ST_WAIT_B;
                ST_WAIT_B: if (ll_fin_flag || ll_fin) kk_st <= ST_NEXT;
                ST_NEXT:   kk_st <= kk_last ? ST_IDLE : ST_TRIG_A;
                default:   kk_st <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            ll_st <= ST_IDLE;
        end else begin
            case (ll_st)
                ST_IDLE:   if (ll_go) ll_st <= ST_TRIG_A;
                ST_TRIG_A: ll_st <= ST_WAIT_A;
                ST_WAIT_A: if (eng_ok[ENG_IC]) ll_st <= ST_NEXT;
                ST_NEXT:   ll_st <= ll_last ? ST_IDLE : ST_TRIG_A;
                default:   ll_st <= ST_IDLE;
            endcase
        end
    end

    // Indices move only on NEXT; finishing a level returns them to zero.
    assign hh_adv = (hh_st == ST_NEXT) && !hh_last;
    assign kk_adv = (kk_st == ST_NEXT) && !kk_last;
    assign ll_adv = (ll_st == ST_NEXT) && !ll_last;
    assign hh_clr = abort || hh_fin;
    assign kk_clr = abort || kk_fin;
    assign ll_clr = abort || ll_fin;

    qconv_loop_idx2d #(.W(HW_W)) u_ihw_high (
        .clk     (clk),
        .rst     (rst),
        .clear   (hh_clr),
        .advance (hh_adv),
        .num_h   (ihh_num_q),
        .num_w   (iwh_num_q),
        .h       (ih_high),
        .w       (iw_high),
        .is_last (hh_last)
    );

    qconv_loop_idx2d #(.W(K_W)) u_khw (
        .clk     (clk),
        .rst     (rst),
        .clear   (kk_clr),
        .advance (kk_adv),
        .num_h   (kh_num_q),
        .num_w   (kw_num_q),
        .h       (kh),
        .w       (kw),
        .is_last (kk_last)
    );

    qconv_loop_idx2d #(.W(HW_W)) u_ihw_low (
        .clk     (clk),
        .rst     (rst),
        .clear   (ll_clr),
        .advance (ll_adv),
        .num_h   (ihl_num_q),
        .num_w   (iwl_num_q),
        .h       (ih_low),
        .w       (iw_low),
        .is_last (ll_last)
    );

    assign oc_high = oc_idx;
    assign busy    = (oc_st != ST_IDLE);
    assign done    = (oc_st == ST_NEXT) && oc_last && !kill;

endmodule

// File: tb/tb_qconv_loop_ctrl.sv
// Directed bench for qconv_loop_ctrl: engine responders with fixed or random
// latency, start-cycle/count bookkeeping, abort/reset and ignore-cases.
module tb_qconv_loop_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [7:0] cfg_oc_num, cfg_ihh_num, cfg_iwh_num, cfg_ihl_num, cfg_iwl_num;
    logic [3:0] cfg_kh_num, cfg_kw_num;
    logic       cfg_thr_en;
    logic [5:0] eng_start, eng_done, model_done, inj_done;
    logic       busy, done;
    logic [7:0] oc_high, ih_high, iw_high, ih_low, iw_low;
    logic [3:0] kh, kw;

    typedef struct {
        logic [7:0] oc, ihh, iwh, ihl, iwl;
        logic [3:0] kh, kw;
        logic       thr;
    } job_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int t0  = 0;
    bit rand_lat = 1'b0;
    int lat_fix[6];
    int dn[6];
    int st_cnt[6];
    int st_first[6];
    int done_cnt, done_rel, busy_rise, busy_fall;
    int kidx_n, kidx_err, k3_kh, k3_kw;
    int cur_kh = 1;
    int cur_kw = 1;

    assign eng_done = model_done | inj_done;

    qconv_loop_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .cfg_oc_num  (cfg_oc_num),
        .cfg_ihh_num (cfg_ihh_num),
        .cfg_iwh_num (cfg_iwh_num),
        .cfg_kh_num  (cfg_kh_num),
        .cfg_kw_num  (cfg_kw_num),
        .cfg_ihl_num (cfg_ihl_num),
        .cfg_iwl_num (cfg_iwl_num),
        .cfg_thr_en  (cfg_thr_en),
        .eng_start   (eng_start),
        .eng_done    (eng_done),
        .busy        (busy),
        .done        (done),
        .oc_high     (oc_high),
        .ih_high     (ih_high),
        .iw_high     (iw_high),
        .kh          (kh),
        .kw          (kw),
        .ih_low      (ih_low),
        .iw_low      (iw_low)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Engine responders plus observation, all sampled mid-cycle.
    initial begin
        model_done = '0;
        for (int i = 0; i < 6; i++) dn[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 6; i++) begin
                model_done[i] = 1'b0;
                if (dn[i] > 0) begin
                    dn[i]--;
                    if (dn[i] == 0) model_done[i] = 1'b1;
                end
                if (eng_start[i]) begin
                    st_cnt[i]++;
                    if (st_first[i] < 0) st_first[i] = cyc - t0;
                    dn[i] = rand_lat ? int'($urandom_range(10, 1)) : lat_fix[i];
                end
            end
            if (eng_start[2]) begin
                int p;
                p = kidx_n % (cur_kh * cur_kw);
                if (int'(kw) != p % cur_kw || int'(kh) != p / cur_kw) kidx_err++;
                if (kidx_n == 3) begin
                    k3_kh = int'(kh);
                    k3_kw = int'(kw);
                end
                kidx_n++;
            end
            if (done) begin
                done_cnt++;
                done_rel = cyc - t0;
            end
            if (busy && busy_rise < 0) busy_rise = cyc - t0;
            if (!busy && busy_rise >= 0 && busy_fall < 0) busy_fall = cyc - t0;
        end
    end

    task automatic clear_stats();
        for (int i = 0; i < 6; i++) begin
            st_cnt[i]   = 0;
            st_first[i] = -1;
        end
        done_cnt  = 0;
        done_rel  = -1;
        busy_rise = -1;
        busy_fall = -1;
        kidx_n    = 0;
        kidx_err  = 0;
        k3_kh     = -1;
        k3_kw     = -1;
    endtask

    task automatic launch(input job_t j);
        @(posedge clk);
        #1;
        clear_stats();
        cfg_oc_num  = j.oc;
        cfg_ihh_num = j.ihh;
        cfg_iwh_num = j.iwh;
        cfg_kh_num  = j.kh;
        cfg_kw_num  = j.kw;
        cfg_ihl_num = j.ihl;
        cfg_iwl_num = j.iwl;
        cfg_thr_en  = j.thr;
        cur_kh = (j.kh == 0) ? 1 : int'(j.kh);
        cur_kw = (j.kw == 0) ? 1 : int'(j.kw);
        start = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit saw = 1'b0;
        bit ok  = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            if (busy) saw = 1'b1;
            else if (saw) ok = 1'b1;
        end
        check({tag, "_finished"}, ok, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_ref(input string tag);
        int exp_first[6];
        exp_first = '{2, 2, 5, 8, 1, 13};
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s_first%0d", tag, i), st_first[i], exp_first[i]);
            check($sformatf("%s_cnt%0d", tag, i), st_cnt[i], 1);
        end
        check({tag, "_done_cyc"}, done_rel, 15);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_busy_rise"}, busy_rise, 1);
        check({tag, "_busy_fall"}, busy_fall, 16);
    endtask

    task automatic check_idx_zero(input string tag);
        check({tag, "_idx"}, {oc_high, ih_high, iw_high, kh, kw, ih_low, iw_low}, 0);
    endtask

    job_t ref_job, big_job, zero_job;
    int   exp_big[6];

    initial begin
        ref_job  = '{oc: 8'd1, ihh: 8'd1, iwh: 8'd1, ihl: 8'd1, iwl: 8'd1,
                     kh: 4'd1, kw: 4'd1, thr: 1'b1};
        big_job  = '{oc: 8'd2, ihh: 8'd2, iwh: 8'd1, ihl: 8'd2, iwl: 8'd2,
                     kh: 4'd3, kw: 4'd3, thr: 1'b1};
        zero_job = '{oc: 8'd0, ihh: 8'd0, iwh: 8'd0, ihl: 8'd0, iwl: 8'd0,
                     kh: 4'd0, kw: 4'd0, thr: 1'b0};
        exp_big  = '{4, 4, 36, 144, 2, 2};
        for (int i = 0; i < 6; i++) lat_fix[i] = 1;
        clear_stats();
        rst = 1'b1; start = 1'b0; abort = 1'b0; inj_done = '0;
        cfg_oc_num = '0; cfg_ihh_num = '0; cfg_iwh_num = '0; cfg_kh_num = '0;
        cfg_kw_num = '0; cfg_ihl_num = '0; cfg_iwl_num = '0; cfg_thr_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_eng_start", eng_start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check_idx_zero("rst");

        // Reference timing.
        launch(ref_job);
        wait_idle("ref", 200);
        check_ref("ref");
        check_idx_zero("ref_end");

        // Larger job, random engine latency, thresholds on then bypassed.
        rand_lat = 1'b1;
        launch(big_job);
        wait_idle("big", 20000);
        for (int i = 0; i < 6; i++) check($sformatf("big_cnt%0d", i), st_cnt[i], exp_big[i]);
        check("big_done_cnt", done_cnt, 1);
        check("big_kidx_err", kidx_err, 0);
        check("big_k3_kh", k3_kh, 1);
        check("big_k3_kw", k3_kw, 0);
        check_idx_zero("big_end");

        big_job.thr = 1'b0;
        launch(big_job);
        wait_idle("nothr", 20000);
        for (int i = 0; i < 6; i++)
            check($sformatf("nothr_cnt%0d", i), st_cnt[i], (i == 4) ? 0 : exp_big[i]);
        check("nothr_done_cnt", done_cnt, 1);
        rand_lat = 1'b0;

        // Zero counts clamp to one; thresholds enabled for the timing comparison.
        zero_job.thr = 1'b1;
        launch(zero_job);
        wait_idle("zero", 200);
        check_ref("zero");

        // Abort exactly in the read_kernel TRIG cycle.
        launch(ref_job);
        repeat (4) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abt_trig_busy", busy, 0);
        repeat (6) @(posedge clk);
        #1;
        check("abt_trig_rk_cnt", st_cnt[2], 0);
        check("abt_trig_done_cnt", done_cnt, 0);

        // Abort while ic waits; its late done must be ignored.
        lat_fix[3] = 6;
        launch(ref_job);
        for (int n = 0; n < 50 && st_cnt[3] == 0; n++) begin
            @(posedge clk);
            #1;
        end
        check("abt_ic_started", st_cnt[3], 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abt_ic_busy", busy, 0);
        check_idx_zero("abt_ic");
        repeat (8) @(posedge clk);
        #1;
        check("abt_ic_done_cnt", done_cnt, 0);
        check("abt_ic_out_cnt", st_cnt[5], 0);
        check("abt_ic_busy_late", busy, 0);
        lat_fix[3] = 1;
        launch(ref_job);
        wait_idle("post_abt", 200);
        check_ref("post_abt");

        // Mid-job reset.
        launch(ref_job);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check_idx_zero("midrst");
        repeat (6) @(posedge clk);
        #1;
        check("midrst_done_cnt", done_cnt, 0);

        // Spurious read_kernel done in IDLE, then start re-pulsed while busy.
        inj_done[2] = 1'b1;
        @(posedge clk);
        #1;
        inj_done[2] = 1'b0;
        launch(ref_job);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("ign", 200);
        check_ref("ign");
        repeat (4) @(posedge clk);
        #1;
        check("ign_busy_after", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
